// File: rtl/ram_rr_arbiter.sv
// Round-robin read/write arbiter sharing one ram_1r1w_sync between num_req_p requesters.
// Define RAM_RR_ARBITER_BYPASS_EN to forward same-cycle write data to a colliding read.
module ram_rr_arbiter #(
  parameter int width_p   = 8,
  parameter int depth_p   = 512,
  parameter int num_req_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           rd_valid_i,
  input  logic [num_req_p*$clog2(depth_p)-1:0] rd_addr_i,
  output logic [num_req_p-1:0]           rd_ready_o,
  input  logic [num_req_p-1:0]           wr_valid_i,
  input  logic [num_req_p*$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [num_req_p*width_p-1:0]   wr_data_i,
  output logic [num_req_p-1:0]           wr_ready_o,
  output logic [num_req_p-1:0]           resp_valid_o,
  output logic [width_p-1:0]             resp_data_o,
  output logic                           ram_rd_valid_o,
  output logic [$clog2(depth_p)-1:0]     ram_rd_addr_o,
  input  logic [width_p-1:0]             ram_rd_data_i,
  output logic                           ram_wr_valid_o,
  output logic [$clog2(depth_p)-1:0]     ram_wr_addr_o,
  output logic [width_p-1:0]             ram_wr_data_o
);
  localparam int addr_w = $clog2(depth_p);
  localparam int id_w   = $clog2(num_req_p);

  logic [addr_w-1:0]    rd_addr_arr [num_req_p];
  logic [addr_w-1:0]    wr_addr_arr [num_req_p];
  logic [width_p-1:0]   wr_data_arr [num_req_p];

  logic [id_w-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic                 resp_vld_reg;
  logic [id_w-1:0]      resp_id_reg;
  logic [num_req_p-1:0] rd_gnt, wr_gnt;
  logic [id_w-1:0]      rd_idx, wr_idx;

  // First requester at or after ptr, wrapping modulo num_req_p.
  function automatic logic [num_req_p-1:0] rr_pick(input logic [num_req_p-1:0] req,
                                                   input logic [id_w-1:0] ptr);
    logic [num_req_p-1:0] gnt;
    logic                 found;
    int                   idx;
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < num_req_p; off++) begin
      idx = (int'(ptr) + off) % num_req_p;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [id_w-1:0] gnt_index(input logic [num_req_p-1:0] gnt);
    logic [id_w-1:0] k;
    k = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (gnt[i]) k = id_w'(i);
    end
    return k;
  endfunction

  function automatic logic [id_w-1:0] ptr_after(input logic [id_w-1:0] k);
    return id_w'((int'(k) + 1) % num_req_p);
  endfunction

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
      assign rd_addr_arr[gi]  = rd_addr_i[gi*addr_w +: addr_w];
      assign wr_addr_arr[gi]  = wr_addr_i[gi*addr_w +: addr_w];
      assign wr_data_arr[gi]  = wr_data_i[gi*width_p +: width_p];
      assign resp_valid_o[gi] = resp_vld_reg && (resp_id_reg == id_w'(gi));
    end
  endgenerate

  // Grants are masked by reset so nothing reaches the RAM while it is held.
  assign rd_gnt = reset_i ? '0 : rr_pick(rd_valid_i, rd_ptr_reg);
  assign wr_gnt = reset_i ? '0 : rr_pick(wr_valid_i, wr_ptr_reg);
  assign rd_idx = gnt_index(rd_gnt);
  assign wr_idx = gnt_index(wr_gnt);

  assign rd_ready_o     = rd_gnt;
  assign wr_ready_o     = wr_gnt;
  assign ram_rd_valid_o = |rd_gnt;
  assign ram_wr_valid_o = |wr_gnt;
  assign ram_rd_addr_o  = rd_addr_arr[rd_idx];
  assign ram_wr_addr_o  = wr_addr_arr[wr_idx];
  assign ram_wr_data_o  = wr_data_arr[wr_idx];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      resp_vld_reg <= 1'b0;
      resp_id_reg  <= '0;
    end else begin
      resp_vld_reg <= ram_rd_valid_o;
      if (ram_rd_valid_o) begin
        rd_ptr_reg  <= ptr_after(rd_idx);
        resp_id_reg <= rd_idx;
      end
      if (ram_wr_valid_o) begin
        wr_ptr_reg <= ptr_after(wr_idx);
      end
    end
  end

`ifdef RAM_RR_ARBITER_BYPASS_EN
  logic               hit_reg;
  logic [width_p-1:0] byp_data_reg;

  // The RAM reads before it writes, so a colliding read would see stale data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      hit_reg      <= ram_rd_valid_o && ram_wr_valid_o && (ram_rd_addr_o == ram_wr_addr_o);
      byp_data_reg <= ram_wr_data_o;
    end
  end

  assign resp_data_o = hit_reg ? byp_data_reg : ram_rd_data_i;
`else
  assign resp_data_o = ram_rd_data_i;
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: behavioural RAM, reference model, directed and random traffic.
module tb_ram_rr_arbiter;
  localparam int W  = 8;
  localparam int D  = 512;
  localparam int N  = 4;
  localparam int AW = 9;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N-1:0]    rd_valid_i, wr_valid_i, rd_ready_o, wr_ready_o, resp_valid_o;
  logic [N*AW-1:0] rd_addr_i, wr_addr_i;
  logic [N*W-1:0]  wr_data_i;
  logic [W-1:0]    resp_data_o, ram_wr_data_o;
  logic [W-1:0]    ram_rd_data_i = '0;
  logic            ram_rd_valid_o, ram_wr_valid_o;
  logic [AW-1:0]   ram_rd_addr_o, ram_wr_addr_o;

  logic [AW-1:0]   rd_addr_a [N];
  logic [AW-1:0]   wr_addr_a [N];
  logic [W-1:0]    wr_data_a [N];

  logic [W-1:0]    mem [D] = '{default: '0};

  logic [W-1:0]    m_mem [D];
  int              m_rd_ptr, m_wr_ptr, m_resp_id;
  bit              m_resp_vld;
  logic [W-1:0]    m_resp_data;
  logic [N-1:0]    rd_acc, wr_acc;
  int              checks   = 0;
  int              failures = 0;

  ram_rr_arbiter #(.width_p(W), .depth_p(D), .num_req_p(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .ram_rd_valid_o(ram_rd_valid_o), .ram_rd_addr_o(ram_rd_addr_o),
    .ram_rd_data_i(ram_rd_data_i),
    .ram_wr_valid_o(ram_wr_valid_o), .ram_wr_addr_o(ram_wr_addr_o),
    .ram_wr_data_o(ram_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    rd_addr_i = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    for (int i = 0; i < N; i++) begin
      rd_addr_i[i*AW +: AW] = rd_addr_a[i];
      wr_addr_i[i*AW +: AW] = wr_addr_a[i];
      wr_data_i[i*W +: W]   = wr_data_a[i];
    end
  end

  // Synchronous read-before-write RAM standing in for ram_1r1w_sync.
  always @(posedge clk_i) begin
    if (ram_rd_valid_o) ram_rd_data_i <= mem[ram_rd_addr_o];
    if (ram_wr_valid_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Winner is the requesting index with the smallest circular distance from ptr.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - ptr + N) % N) < bestd) begin
        best  = i;
        bestd = (i - ptr + N) % N;
      end
    end
    return best;
  endfunction

  initial begin : compare
    int rk, wk;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_rd_ptr = 0; m_wr_ptr = 0; m_resp_vld = 0; m_resp_id = 0; m_resp_data = '0;
    rd_acc = '0; wr_acc = '0;
    forever begin
      @(negedge clk_i);
      #3;
      if (reset_i) begin
        chk("rst_rd_ready", 32'(rd_ready_o), 0);
        chk("rst_wr_ready", 32'(wr_ready_o), 0);
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        chk("rst_ram_valids", {30'd0, ram_rd_valid_o, ram_wr_valid_o}, 0);
        m_rd_ptr = 0; m_wr_ptr = 0; m_resp_vld = 0;
        rd_acc = '0; wr_acc = '0;
      end else begin
        chk("resp_valid", 32'(resp_valid_o), m_resp_vld ? (32'd1 << m_resp_id) : 32'd0);
        if (m_resp_vld) chk("resp_data", 32'(resp_data_o), 32'(m_resp_data));
        rk = pick(rd_valid_i, m_rd_ptr);
        wk = pick(wr_valid_i, m_wr_ptr);
        chk("rd_ready", 32'(rd_ready_o), (rk >= 0) ? (32'd1 << rk) : 32'd0);
        chk("wr_ready", 32'(wr_ready_o), (wk >= 0) ? (32'd1 << wk) : 32'd0);
        chk("ram_rd_valid", 32'(ram_rd_valid_o), 32'(rk >= 0));
        chk("ram_wr_valid", 32'(ram_wr_valid_o), 32'(wk >= 0));
        chk("ram_rd_addr", 32'(ram_rd_addr_o), 32'(rd_addr_a[(rk >= 0) ? rk : 0]));
        chk("ram_wr_addr", 32'(ram_wr_addr_o), 32'(wr_addr_a[(wk >= 0) ? wk : 0]));
        chk("ram_wr_data", 32'(ram_wr_data_o), 32'(wr_data_a[(wk >= 0) ? wk : 0]));
        m_resp_vld = (rk >= 0);
        rd_acc = '0;
        wr_acc = '0;
        if (rk >= 0) begin
          m_resp_id   = rk;
          m_resp_data = m_mem[rd_addr_a[rk]];
`ifdef RAM_RR_ARBITER_BYPASS_EN
          if (wk >= 0 && wr_addr_a[wk] == rd_addr_a[rk]) m_resp_data = wr_data_a[wk];
`endif
          m_rd_ptr   = (rk + 1) % N;
          rd_acc[rk] = 1'b1;
        end
        if (wk >= 0) begin
          m_mem[wr_addr_a[wk]] = wr_data_a[wk];
          m_wr_ptr   = (wk + 1) % N;
          wr_acc[wk] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  initial begin : stim
    logic [N-1:0] exp_v;
    reset_i    = 1'b1;
    rd_valid_i = '1;
    wr_valid_i = '1;
    for (int i = 0; i < N; i++) begin
      rd_addr_a[i] = '0; wr_addr_a[i] = '0; wr_data_a[i] = '0;
    end

    // Grants forced off while reset is held, even with every request up.
    tick(); #2;
    chk("reset_rd_ready", 32'(rd_ready_o), 32'h0);
    chk("reset_wr_ready", 32'(wr_ready_o), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid_o), 32'h0);
    tick(); reset_i = 1'b0; rd_valid_i = '0; wr_valid_i = '0;

    // Move wr_ptr to 3, then independent read/write arbitration.
    tick(); wr_valid_i = 4'b0100; wr_addr_a[2] = 9'd20; wr_data_a[2] = 8'h11; #2;
    chk("setup_wr_ready", 32'(wr_ready_o), 32'b0100);
    tick(); wr_valid_i = 4'b1001; wr_addr_a[3] = 9'd30; wr_data_a[3] = 8'h33;
    wr_addr_a[0] = 9'd31; wr_data_a[0] = 8'h44;
    rd_valid_i = 4'b0011; rd_addr_a[0] = 9'd50; rd_addr_a[1] = 9'd51; #2;
    chk("indep_wr_first", 32'(wr_ready_o), 32'b1000);
    chk("indep_rd_first", 32'(rd_ready_o), 32'b0001);
    tick(); wr_valid_i = 4'b0001; rd_valid_i = 4'b0010; #2;
    chk("indep_wr_second", 32'(wr_ready_o), 32'b0001);
    chk("indep_rd_second", 32'(rd_ready_o), 32'b0010);
    tick(); wr_valid_i = '0; rd_valid_i = '0;

    // Write 0xA5 to addr 5, then requester 2 reads it back.
    tick(); wr_valid_i = 4'b0001; wr_addr_a[0] = 9'd5; wr_data_a[0] = 8'hA5; #2;
    chk("a5_wr_ready", 32'(wr_ready_o), 32'b0001);
    tick(); wr_valid_i = '0; rd_valid_i = 4'b0100; rd_addr_a[2] = 9'd5; #2;
    chk("a5_rd_ready", 32'(rd_ready_o), 32'b0100);
    tick(); rd_valid_i = '0; #2;
    chk("a5_resp_valid", 32'(resp_valid_o), 32'b0100);
    chk("a5_resp_data", 32'(resp_data_o), 32'hA5);

    // Same-address read and write in one cycle.
    tick(); wr_valid_i = 4'b0010; wr_addr_a[1] = 9'd10; wr_data_a[1] = 8'h3C;
    rd_valid_i = 4'b1000; rd_addr_a[3] = 9'd10; #2;
    chk("coll_rd_ready", 32'(rd_ready_o), 32'b1000);
    chk("coll_wr_ready", 32'(wr_ready_o), 32'b0010);
    tick(); wr_valid_i = '0; rd_valid_i = '0; #2;
    chk("coll_resp_valid", 32'(resp_valid_o), 32'b1000);
`ifdef RAM_RR_ARBITER_BYPASS_EN
    chk("coll_resp_data", 32'(resp_data_o), 32'h3C);
`else
    chk("coll_resp_data", 32'(resp_data_o), 32'h00);
`endif

    // All four read continuously: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < N; i++) rd_addr_a[i] = AW'(40 + i);
    for (int c = 0; c < 8; c++) begin
      tick(); rd_valid_i = '1; #2;
      chk("rr_rd_ready", 32'(rd_ready_o), 32'd1 << (c % 4));
      if (c > 0) chk("rr_resp_valid", 32'(resp_valid_o), 32'd1 << ((c - 1) % 4));
    end
    tick(); rd_valid_i = '0; #2;
    chk("rr_last_resp", 32'(resp_valid_o), 32'b1000);

    // Lone requester 1 toggling its request.
    rd_addr_a[1] = 9'd60;
    for (int c = 0; c < 6; c++) begin
      tick(); rd_valid_i = (c % 2 == 0) ? 4'b0010 : 4'b0000; #2;
      chk("alt_rd_ready", 32'(rd_ready_o), (c % 2 == 0) ? 32'b0010 : 32'b0000);
    end
    for (int c = 0; c < 4; c++) begin
      tick(); rd_valid_i = '1; #2;
      chk("alt_ptr_follow", 32'(rd_ready_o), 32'd1 << ((c + 2) % 4));
    end
    tick(); rd_valid_i = '0;

    // Async reset during the response cycle drops the response at once.
    tick(); rd_valid_i = 4'b0100; rd_addr_a[2] = 9'd5; #2;
    chk("arst_grant", 32'(rd_ready_o), 32'b0100);
    @(posedge clk_i); #1;
    rd_valid_i = '0;
    chk("arst_resp_before", 32'(resp_valid_o), 32'b0100);
    #1 reset_i = 1'b1;
    #1 chk("arst_resp_dropped", 32'(resp_valid_o), 32'h0);
    tick(); rd_valid_i = '1; #2;
    chk("arst_held_ready", 32'(rd_ready_o), 32'h0);
    tick(); reset_i = 1'b0; #2;
    chk("arst_first_grant", 32'(rd_ready_o), 32'b0001);
    for (int c = 0; c < 4; c++) begin
      tick(); rd_valid_i = rd_valid_i & ~rd_acc;
    end
    tick(); rd_valid_i = '0; wr_valid_i = '0;

    // Random traffic; unaccepted requests are held stable.
    for (int c = 0; c < 2000; c++) begin
      tick();
      reset_i = ($urandom_range(0, 299) == 0);
      exp_v = rd_valid_i & ~rd_acc;
      for (int i = 0; i < N; i++) begin
        if (!exp_v[i]) begin
          rd_valid_i[i] = $urandom_range(0, 1);
          rd_addr_a[i]  = AW'($urandom_range(0, 15));
        end
      end
      exp_v = wr_valid_i & ~wr_acc;
      for (int i = 0; i < N; i++) begin
        if (!exp_v[i]) begin
          wr_valid_i[i] = $urandom_range(0, 1);
          wr_addr_a[i]  = AW'($urandom_range(0, 15));
          wr_data_a[i]  = W'($urandom_range(0, 255));
        end
      end
    end
    tick(); reset_i = 1'b0; rd_valid_i = '0; wr_valid_i = '0;
    tick(); tick(); #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
